// File: rtl/mem_arbiter.sv
// Purpose : shares one synchronous data-RAM port between the core and an external host.
// Latency : grant 1 cycle after request from idle; read data valid 1 cycle after the granted read.
// Backpr. : core has priority and is stalled (c_stall) while denied; host waits at most MAXWAIT cycles.
//
// Ports:
//   clk, rst_n                          clock (rising edge), asynchronous active-low reset
//   c_req/c_wt/c_addr/c_wdata           core request, write flag, address, write data
//   c_gnt, c_stall, c_rvalid, c_rdata   core grant (registered), stall, read return
//   h_req/h_wt/h_addr/h_wdata           host request, write flag, address, write data
//   h_gnt, h_rvalid, h_rdata            host grant (registered), read return
//   m_addr/m_wt/m_wdata, m_rdata        RAM port; m_rdata is valid one cycle after m_addr
module mem_arbiter #(
    parameter int NBADD   = 10,
    parameter int NBITS   = 16,
    parameter int MAXWAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_req,
    input  logic             c_wt,
    input  logic [NBADD-1:0] c_addr,
    input  logic [NBITS-1:0] c_wdata,
    output logic             c_gnt,
    output logic             c_stall,
    output logic             c_rvalid,
    output logic [NBITS-1:0] c_rdata,
    input  logic             h_req,
    input  logic             h_wt,
    input  logic [NBADD-1:0] h_addr,
    input  logic [NBITS-1:0] h_wdata,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic [NBITS-1:0] h_rdata,
    output logic [NBADD-1:0] m_addr,
    output logic             m_wt,
    output logic [NBITS-1:0] m_wdata,
    input  logic [NBITS-1:0] m_rdata
);

    localparam int WCW = $clog2(MAXWAIT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAXWAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } own_t;

    own_t           r_own;
    own_t           w_own_nxt;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_wait_nxt;
    logic           r_c_rvalid;
    logic           r_h_rvalid;
    logic           w_forced;
    logic           w_c_acc;
    logic           w_h_acc;

    // Grants come straight from the ownership register, so they are glitch-free
    // and clear the instant reset is asserted.
    assign c_gnt    = (r_own == CORE);
    assign h_gnt    = (r_own == HOST);
    assign c_stall  = c_req & ~c_gnt;
    assign c_rvalid = r_c_rvalid;
    assign h_rvalid = r_h_rvalid;
    assign c_rdata  = m_rdata;
    assign h_rdata  = m_rdata;

    // An access only happens when the owner is also requesting this cycle.
    assign w_c_acc  = c_gnt & c_req;
    assign w_h_acc  = h_gnt & h_req;

    // Host has waited long enough: steal the next cycle from the core.
    assign w_forced = h_req & (r_wait_cnt == WAIT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own      <= IDLE;
            r_wait_cnt <= '0;
            r_c_rvalid <= 1'b0;
            r_h_rvalid <= 1'b0;
        end else begin
            r_own      <= w_own_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_c_rvalid <= w_c_acc & ~c_wt;
            r_h_rvalid <= w_h_acc & ~h_wt;
        end
    end

    always_comb begin
        w_own_nxt  = r_own;
        w_wait_nxt = r_wait_cnt;
        m_addr     = c_addr;
        m_wdata    = c_wdata;
        m_wt       = 1'b0;

        case (r_own)
            IDLE: begin
                if (c_req)      w_own_nxt = CORE;
                else if (h_req) w_own_nxt = HOST;
                else            w_own_nxt = IDLE;
            end
            CORE: begin
                if (w_forced)   w_own_nxt = HOST;
                else if (c_req) w_own_nxt = CORE;
                else if (h_req) w_own_nxt = HOST;
                else            w_own_nxt = IDLE;
            end
            HOST: begin
                // Core always reclaims the port after a single host cycle.
                if (c_req)      w_own_nxt = CORE;
                else if (h_req) w_own_nxt = HOST;
                else            w_own_nxt = IDLE;
            end
            default: w_own_nxt = IDLE;
        endcase

        // Counts cycles the host has been kept off the port; saturates so the
        // forced hand-over condition stays asserted until it is taken.
        if (!h_req || r_own == HOST) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end

        if (r_own == HOST) begin
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end
        m_wt = (w_c_acc & c_wt) | (w_h_acc & h_wt);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
// Latency : RAM model returns read data one cycle after the address.
// Backpr. : none; requesters are driven by directed tasks that hold requests until granted.
module tb_mem_arbiter;

    localparam int NBADD   = 10;
    localparam int NBITS   = 16;
    localparam int MAXWAIT = 4;

    logic             clk;
    logic             rst_n;
    logic             c_req, c_wt, c_gnt, c_stall, c_rvalid;
    logic [NBADD-1:0] c_addr;
    logic [NBITS-1:0] c_wdata, c_rdata;
    logic             h_req, h_wt, h_gnt, h_rvalid;
    logic [NBADD-1:0] h_addr;
    logic [NBITS-1:0] h_wdata, h_rdata;
    logic [NBADD-1:0] m_addr;
    logic             m_wt;
    logic [NBITS-1:0] m_wdata, m_rdata;

    logic [NBITS-1:0] mem [0:(1<<NBADD)-1];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_arbiter #(.NBADD(NBADD), .NBITS(NBITS), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_wt(c_wt), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_wt(h_wt), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_addr(m_addr), .m_wt(m_wt), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: write on strobe, registered read of the presented address.
    always @(posedge clk) begin
        if (m_wt) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    // Step into the drive window of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        c_req = 1'b0;
        h_req = 1'b0;
        c_wt  = 1'b0;
        h_wt  = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; c_req = 1'b1; h_req = 1'b1; c_wt = 1'b0; h_wt = 1'b0;
        c_addr = '0; h_addr = '0; c_wdata = '0; h_wdata = '0;
        #1;
        chk_cnt++; if ({c_gnt, h_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b required 00", {c_gnt, h_gnt}); else pass_cnt++;
        chk_cnt++; if (m_wt !== 1'b0) $display("FAIL rst_m_wt: got %b required 0", m_wt); else pass_cnt++;
        chk_cnt++; if (c_stall !== 1'b1) $display("FAIL rst_stall: got %b required 1", c_stall); else pass_cnt++;
        chk_cnt++; if ({c_rvalid, h_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b required 00", {c_rvalid, h_rvalid}); else pass_cnt++;
        #7 rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt, c_stall} !== 3'b100) $display("FAIL rst_release: got gnt/hgnt/stall=%b required 100", {c_gnt, h_gnt, c_stall}); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_core_only();
        c_req = 1'b1; c_wt = 1'b1; c_addr = 10'd3; c_wdata = 16'h00A5;
        @(negedge clk);
        chk_cnt++; if ({c_gnt, c_stall, m_wt} !== 3'b010) $display("FAIL core_req_cycle: got gnt/stall/wt=%b required 010", {c_gnt, c_stall, m_wt}); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({c_gnt, c_stall, m_wt} !== 3'b101) $display("FAIL core_wr_cycle: got gnt/stall/wt=%b required 101", {c_gnt, c_stall, m_wt}); else pass_cnt++;
        chk_cnt++; if (m_addr !== 10'd3 || m_wdata !== 16'h00A5) $display("FAIL core_wr_bus: got addr=%0h data=%0h required 3/a5", m_addr, m_wdata); else pass_cnt++;
        next_cycle();
        c_wt = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({c_gnt, m_wt, c_rvalid} !== 3'b100) $display("FAIL core_rd_cycle: got gnt/wt/rvalid=%b required 100", {c_gnt, m_wt, c_rvalid}); else pass_cnt++;
        next_cycle();
        c_req = 1'b0;
        @(negedge clk);
        chk_cnt++; if (c_rvalid !== 1'b1 || c_rdata !== 16'h00A5) $display("FAIL core_rd_data: got rvalid=%b data=%0h required 1/a5", c_rvalid, c_rdata); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({c_rvalid, c_gnt} !== 2'b00) $display("FAIL core_release: got rvalid/gnt=%b required 00", {c_rvalid, c_gnt}); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_priority();
        c_req = 1'b1; c_wt = 1'b0; c_addr = 10'd3;
        h_req = 1'b1; h_wt = 1'b0; h_addr = 10'h010;
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt} !== 2'b00) $display("FAIL prio_idle: got %b required 00", {c_gnt, h_gnt}); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt} !== 2'b10 || m_addr !== 10'd3) $display("FAIL prio_core_wins: got gnt=%b addr=%0h required 10/3", {c_gnt, h_gnt}, m_addr); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_host_load();
        int bubbles;
        bubbles = 0;
        h_req = 1'b1; h_wt = 1'b1; h_addr = 10'd0; h_wdata = 16'h1234;
        @(negedge clk);
        chk_cnt++; if (h_gnt !== 1'b0) $display("FAIL host_first: got %b required 0", h_gnt); else pass_cnt++;
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            h_addr = NBADD'(i);
            @(negedge clk);
            if (h_gnt !== 1'b1 || m_wt !== 1'b1 || m_addr !== NBADD'(i) || m_wdata !== 16'h1234) bubbles++;
            next_cycle();
        end
        chk_cnt++; if (bubbles !== 0) $display("FAIL host_stream: got %0d bad cycles required 0", bubbles); else pass_cnt++;
        h_wt = 1'b0; h_addr = 10'd5;
        @(negedge clk);
        chk_cnt++; if ({h_gnt, m_wt} !== 2'b10) $display("FAIL host_rd_cycle: got gnt/wt=%b required 10", {h_gnt, m_wt}); else pass_cnt++;
        next_cycle();
        h_req = 1'b0;
        @(negedge clk);
        chk_cnt++; if (h_rvalid !== 1'b1 || h_rdata !== 16'h1234) $display("FAIL host_rd_data: got rvalid=%b data=%0h required 1/1234", h_rvalid, h_rdata); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({h_gnt, h_rvalid} !== 2'b00) $display("FAIL host_release: got gnt/rvalid=%b required 00", {h_gnt, h_rvalid}); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        c_req = 1'b1; c_wt = 1'b0; c_addr = 10'd0;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            c_addr = NBADD'(i);
            @(negedge clk);
            if (c_gnt !== 1'b1 || c_stall !== 1'b0) errs++;
            if (i > 0 && (c_rvalid !== 1'b1 || c_rdata !== 16'h1234)) errs++;
            next_cycle();
        end
        c_req = 1'b0;
        chk_cnt++; if (errs !== 0) $display("FAIL b2b_stream: got %0d bad cycles required 0", errs); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (c_rvalid !== 1'b1 || c_rdata !== 16'h1234) $display("FAIL b2b_last: got rvalid=%b data=%0h required 1/1234", c_rvalid, c_rdata); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_fairness();
        c_req = 1'b1; c_wt = 1'b0; c_addr = 10'd3;
        next_cycle();
        h_req = 1'b1; h_wt = 1'b0; h_addr = 10'd7;
        for (int k = 0; k < MAXWAIT; k++) begin
            @(negedge clk);
            chk_cnt++; if ({c_gnt, h_gnt} !== 2'b10) $display("FAIL fair_wait_%0d: got gnt=%b required 10", k, {c_gnt, h_gnt}); else pass_cnt++;
            next_cycle();
        end
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt, c_stall} !== 3'b011 || m_addr !== 10'd7) $display("FAIL fair_slot: got gnt/hgnt/stall=%b addr=%0h required 011/7", {c_gnt, h_gnt, c_stall}, m_addr); else pass_cnt++;
        next_cycle();
        h_req = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt, c_rvalid} !== 3'b100) $display("FAIL fair_regain: got gnt/hgnt/crvalid=%b required 100", {c_gnt, h_gnt, c_rvalid}); else pass_cnt++;
        chk_cnt++; if (h_rvalid !== 1'b1 || h_rdata !== 16'h1234) $display("FAIL fair_host_data: got rvalid=%b data=%0h required 1/1234", h_rvalid, h_rdata); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_async_reset();
        h_req = 1'b1; h_wt = 1'b0; h_addr = 10'd9; h_wdata = 16'h5555;
        next_cycle();
        next_cycle();
        h_wt = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({h_gnt, m_wt, h_rvalid} !== 3'b111) $display("FAIL arst_pre: got gnt/wt/rvalid=%b required 111", {h_gnt, m_wt, h_rvalid}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({h_gnt, m_wt, h_rvalid} !== 3'b000) $display("FAIL arst_abort: got gnt/wt/rvalid=%b required 000", {h_gnt, m_wt, h_rvalid}); else pass_cnt++;
        next_cycle();
        chk_cnt++; if (mem[9] === 16'h5555) $display("FAIL arst_no_write: got mem9=%0h required not 5555", mem[9]); else pass_cnt++;
        h_req = 1'b0;
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_cnt++; if ({c_gnt, h_gnt, m_wt} !== 3'b000) $display("FAIL arst_after: got gnt/hgnt/wt=%b required 000", {c_gnt, h_gnt, m_wt}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_core_only();
        test_priority();
        test_host_load();
        test_back_to_back();
        test_fairness();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
